// File: rtl/mlu_seq.sv
// mlu_seq: nibble-serial MLU sequencer.
// Runs one WIDTH-bit MLU operation through a single shared 4-bit combinational
// slice, one nibble per cycle, LSB first, rippling the carry between nibbles
// from the slice's generate/propagate outputs.
//
// Ports:
//   CLK, N_RST        clock (rising edge), asynchronous active-low reset
//   START, OP, A, B   request, 3-bit opcode and operands (sampled on accept)
//   N_BOOTED          1 while slice memory is not yet loaded; blocks START
//   SLICE_A/B/OP/C_IN registered drive into the shared slice
//   SLICE_OUT         slice result: [3:0] sum, [4] prop, [5] gen, [6] zero
//   BUSY              high while nibbles are in flight
//   DONE              one-cycle pulse, results valid from this cycle
//   RESULT, C_OUT, ZERO, OVF  assembled result and flags, held until next accept
//
// Opcode encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 NOP0, 7 NOP1.
module mlu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             N_BOOTED,
  output logic [3:0]       SLICE_A,
  output logic [3:0]       SLICE_B,
  output logic [2:0]       SLICE_OP,
  output logic             SLICE_C_IN,
  input  logic [7:0]       SLICE_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             C_OUT,
  output logic             ZERO,
  output logic             OVF
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = $clog2(NIBBLES);

  localparam logic [2:0] MLU_ADD = 3'd0;
  localparam logic [2:0] MLU_SUB = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nx;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             zero_acc;

  logic accept;
  logic is_arith;
  logic last;
  logic carry_nx;
  logic bx_msb;
  logic ovf_nx;
  logic unused_slice_bit;

  // SLICE_OP doubles as the latched opcode and SLICE_C_IN as the carry register.
  assign accept   = START && !N_BOOTED && (state != S_RUN);
  assign is_arith = (SLICE_OP == MLU_ADD) || (SLICE_OP == MLU_SUB);
  assign last     = (idx == IDX_W'(NIBBLES - 1));
  assign idx_nx   = idx + 1'b1;
  assign carry_nx = SLICE_OUT[5] | (SLICE_OUT[4] & SLICE_C_IN);

  // Subtraction adds ~B, so the effective B sign is inverted for SUB.
  assign bx_msb = b_lat[WIDTH-1] ^ (SLICE_OP == MLU_SUB);
  assign ovf_nx = is_arith && (a_lat[WIDTH-1] == bx_msb) &&
                  (SLICE_OUT[3] != a_lat[WIDTH-1]);

  assign unused_slice_bit = SLICE_OUT[7];

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state      <= S_IDLE;
      idx        <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      zero_acc   <= 1'b0;
      SLICE_A    <= '0;
      SLICE_B    <= '0;
      SLICE_OP   <= '0;
      SLICE_C_IN <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      RESULT     <= '0;
      C_OUT      <= 1'b0;
      ZERO       <= 1'b0;
      OVF        <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          RESULT[{idx, 2'b00} +: 4] <= SLICE_OUT[3:0];
          SLICE_C_IN                <= carry_nx;
          zero_acc                  <= zero_acc & SLICE_OUT[6];
          if (last) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            C_OUT <= is_arith & carry_nx;
            ZERO  <= zero_acc & SLICE_OUT[6];
            OVF   <= ovf_nx;
          end else begin
            // Present the next nibble; on the last one the slice inputs hold.
            idx     <= idx_nx;
            SLICE_A <= a_lat[{idx_nx, 2'b00} +: 4];
            SLICE_B <= b_lat[{idx_nx, 2'b00} +: 4];
          end
        end
        default: begin
          // IDLE and DONE both accept, giving back-to-back operation.
          state <= S_IDLE;
          DONE  <= 1'b0;
          if (accept) begin
            state      <= S_RUN;
            BUSY       <= 1'b1;
            a_lat      <= A;
            b_lat      <= B;
            idx        <= '0;
            zero_acc   <= 1'b1;
            SLICE_A    <= A[3:0];
            SLICE_B    <= B[3:0];
            SLICE_OP   <= OP;
            SLICE_C_IN <= (OP == MLU_SUB);
            RESULT     <= '0;
            C_OUT      <= 1'b0;
            ZERO       <= 1'b0;
            OVF        <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlu_seq.sv
// tb_mlu_seq: scoreboard bench for mlu_seq with a behavioural 4-bit slice.
// Stimulus pushes hand-computed expectations; a monitor pops and compares on
// every DONE pulse.
module tb_mlu_seq;

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_NOP0 = 3'd6;
  localparam logic [2:0] OP_NOP1 = 3'd7;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         n_booted = 1'b0;
  logic [3:0]   slice_a, slice_b;
  logic [2:0]   slice_op;
  logic         slice_c_in;
  logic [7:0]   slice_out;
  logic         busy, done, c_out, zero, ovf;
  logic [W-1:0] result;

  typedef struct {
    int           id;
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mlu_seq #(.WIDTH(W)) dut (
    .CLK(clk), .N_RST(n_rst), .START(start), .OP(op), .A(a), .B(b),
    .N_BOOTED(n_booted), .SLICE_A(slice_a), .SLICE_B(slice_b),
    .SLICE_OP(slice_op), .SLICE_C_IN(slice_c_in), .SLICE_OUT(slice_out),
    .BUSY(busy), .DONE(done), .RESULT(result), .C_OUT(c_out), .ZERO(zero),
    .OVF(ovf)
  );

  // Behavioural slice: ADD/SUB via A + Bx + C_IN, group gen/prop from A + Bx.
  logic [3:0] bx, s4;
  logic [4:0] raw, sum5;
  always_comb begin
    bx   = (slice_op == OP_SUB) ? ~slice_b : slice_b;
    raw  = {1'b0, slice_a} + {1'b0, bx};
    sum5 = raw + {4'b0, slice_c_in};
    s4   = '0;
    slice_out = '0;
    case (slice_op)
      OP_ADD, OP_SUB: s4 = sum5[3:0];
      OP_AND:         s4 = slice_a & slice_b;
      OP_OR:          s4 = slice_a | slice_b;
      OP_XOR:         s4 = slice_a ^ slice_b;
      OP_NOT:         s4 = ~slice_a;
      OP_NOP0:        s4 = 4'h0;
      OP_NOP1:        s4 = 4'hF;
      default:        s4 = 4'h0;
    endcase
    slice_out[3:0] = s4;
    if (slice_op == OP_ADD || slice_op == OP_SUB) begin
      slice_out[4] = (raw == 5'h0F);
      slice_out[5] = raw[4];
    end
    slice_out[6] = (s4 == 4'h0);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("op%0d_result", e.id), result, e.r);
        chk($sformatf("op%0d_c_out", e.id), W'(c_out), W'(e.c));
        chk($sformatf("op%0d_zero", e.id), W'(zero), W'(e.z));
        chk($sformatf("op%0d_ovf", e.id), W'(ovf), W'(e.o));
      end
    end
  end

  // All tasks start and end right after a falling edge.
  task automatic start_op(input int id, input logic [2:0] o, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [W-1:0] er,
                          input logic ec, input logic ez, input logic eo, input bit push);
    exp_t e;
    if (push) begin
      e.id = id; e.r = er; e.c = ec; e.z = ez; e.o = eo;
      sb.push_back(e);
    end
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int busy_cycles);
    n = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 30) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input int id, input logic [2:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] er,
                        input logic ec, input logic ez, input logic eo);
    int n, bc;
    start_op(id, o, va, vb, er, ec, ez, eo, 1'b1);
    wait_done(n, bc);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bc;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), 32'd0);
    chk("rst_done", W'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", W'({c_out, zero, ovf}), 32'd0);
    chk("rst_slice", W'({slice_a, slice_b, slice_op, slice_c_in}), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Carry-through-all-nibbles ADD with latency and BUSY-length checks
    start_op(1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_done(n, bc);
    chk("latency_edges", n, 32'd8);
    chk("busy_cycles", bc, 32'd8);
    @(negedge clk);
    chk("done_one_cycle", W'(done), 32'd0);

    run_op(2,  OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op(3,  OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_op(4,  OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op(5,  OP_SUB,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op(6,  OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0);
    run_op(7,  OP_NOT,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_op(8,  OP_NOP0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_op(9,  OP_AND,  32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1'b0, 1'b0, 1'b0);
    run_op(10, OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0, 1'b0);

    // START held through RUN with changing operands is ignored
    begin
      exp_t e;
      e.id = 11; e.r = 32'h3; e.c = 1'b0; e.z = 1'b0; e.o = 1'b0;
      sb.push_back(e);
      op = OP_ADD; a = 32'h1; b = 32'h2; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op = OP_SUB; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
      repeat (5) @(negedge clk);
      start = 1'b0;
      wait_done(n, bc);
      repeat (12) @(negedge clk);
      chk("held_start_no_requeue", W'(busy), 32'd0);
    end

    // START in the DONE cycle is accepted with no bubble
    start_op(12, OP_ADD, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(n, bc);
    start_op(13, OP_SUB, 32'h7, 32'h7, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("b2b_busy", W'(busy), 32'd1);
    chk("b2b_done_cleared", W'(done), 32'd0);
    wait_done(n, bc);
    chk("b2b_latency", n, 32'd8);
    @(negedge clk);

    // START blocked while N_BOOTED=1
    n_booted = 1'b1;
    start = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("nbooted_busy_%0d", i), W'(busy), 32'd0);
    end
    start = 1'b0;
    n_booted = 1'b0;
    @(negedge clk);

    // Reset mid-operation at idx=3 aborts with no DONE
    start_op(14, OP_ADD, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("abort_busy", W'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", W'({done, c_out, zero, ovf}), 32'd0);
    chk("abort_slice", W'({slice_a, slice_b, slice_op, slice_c_in}), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle", W'(busy), 32'd0);

    run_op(15, OP_ADD, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mlu_seq.md
Name: mlu_seq

Overview:
- Nibble-serial sequencer that runs a full WIDTH-bit MLU operation through a single 4-bit mlu_slice, one nibble per cycle, LSB first.
- Latches operands on START, drives the slice's A/B/OP/C_IN, and ripples carry from each nibble's gen/prop outputs.
- Assembles RESULT and the C_OUT, ZERO and OVF flags.
- Sits between the control unit and one shared slice instance, as the area-reduced alternative to a parallel slice array.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8. NIBBLES = WIDTH/4.

Ports:
- CLK  in  1  clock, rising edge.
- N_RST  in  1  asynchronous active-low reset.
- START  in  1  request; sampled only when accepting.
- OP  in  3  common::MLU_* opcode.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- N_BOOTED  in  1  0 = slice memory loaded; START is ignored while 1.
- SLICE_A  out  4  nibble of A presented to the slice.
- SLICE_B  out  4  nibble of B presented to the slice.
- SLICE_OP  out  3  latched OP.
- SLICE_C_IN  out  1  carry into the current nibble.
- SLICE_OUT  in  8  slice output: [3:0] sum, [4] prop, [5] gen, [6] zero, [7] unused.
- BUSY  out  1  high while nibbles are in flight.
- DONE  out  1  one-cycle pulse; results are valid from this cycle.
- RESULT  out  WIDTH  assembled result; held until the next accepted START.
- C_OUT  out  1  carry out of the MSB nibble (ADD/SUB only, else 0). For SUB, 1 = no borrow.
- ZERO  out  1  high when RESULT == 0.
- OVF  out  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Reset (asynchronous, N_RST=0):
  - State goes to IDLE.
  - BUSY, DONE, RESULT, C_OUT, ZERO, OVF, SLICE_* and all internal registers are 0.
  - Reset mid-operation aborts: partial results are discarded and nothing is pending after release.
- States:
  - IDLE: START=1 and N_BOOTED=0 at an edge gives RUN. A, B and OP are latched, idx=0, carry = (OP==MLU_SUB). RESULT and flags are not cleared until this accept.
  - RUN: BUSY=1. Each edge does the following:
    - Writes SLICE_OUT[3:0] into RESULT[4*idx+:4].
    - Sets carry = SLICE_OUT[5] | (SLICE_OUT[4] & carry).
    - ANDs SLICE_OUT[6] into the zero accumulator.
    - idx++.
    - At idx==NIBBLES-1 the edge goes to DONE and latches the final C_OUT, ZERO and OVF.
  - DONE: DONE=1, BUSY=0 for exactly one cycle, then IDLE. START with N_BOOTED=0 in DONE is accepted exactly as in IDLE (back-to-back, no bubble).
- Slice drive:
  - SLICE_A/SLICE_B are the latched A/B nibbles at idx.
  - SLICE_OP is the latched OP.
  - SLICE_C_IN is the carry register.
  - All are driven from registers only; the slice is combinational, so the loop path is register to slice to register.
  - In IDLE/DONE SLICE_* hold their last values; the slice output is ignored.
- Carry: forced to 0 for AND/OR/XOR/NOT/NOP0/NOP1 (C_OUT=0). The carry register still updates but its value is don't-care.
- OVF:
  - With Bx = B for ADD and ~B for SUB: OVF = (A[W-1]==Bx[W-1]) && (RESULT[W-1]!=A[W-1]).
  - OVF is 0 for other ops.
- Latency: START accepted at edge k; DONE is high in the cycle after edge k+NIBBLES, so it is visible NIBBLES+1 cycles after START (9 for WIDTH=32).
- START is ignored while BUSY and does not queue. Operand changes during RUN have no effect.
- OP values outside MLU_* cannot occur (3-bit opcode, all 8 are defined).

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001 -> RESULT=0x00000000, C_OUT=1, ZERO=1, OVF=0. DONE is high exactly 9 cycles after the START cycle, and BUSY is high for 8 cycles.
- ADD 0x7FFFFFFF + 0x00000001 -> RESULT=0x80000000, C_OUT=0, ZERO=0, OVF=1. SUB 0x80000000 - 0x00000001 -> 0x7FFFFFFF, C_OUT=1, OVF=1.
- SUB 5 - 7 -> RESULT=0xFFFFFFFE, C_OUT=0, OVF=0. SUB 7 - 7 -> RESULT=0, C_OUT=1, ZERO=1.
- XOR 0xA5A5A5A5 ^ 0xFFFFFFFF -> 0x5A5A5A5A, C_OUT=0. NOT A=0xFFFFFFFF -> 0, ZERO=1. NOP0 -> 0, ZERO=1.
- Control cases:
  - START held through RUN with new operands -> ignored.
  - START during the DONE cycle -> new op accepted with no idle cycle.
  - START while N_BOOTED=1 -> BUSY stays 0.
- Reset:
  - N_RST low at RUN idx=3 -> all outputs 0 immediately and no DONE pulse.
  - After release, ADD 1+1 gives RESULT=2.
